alu_share_arb: RTL

Round-robin arbiter and sequencer that shares one `alu_n` instance among `REQ` requesters (decode lanes, address-generation, branch-compare). It accepts one operation at a time over a valid/ready handshake and latches the operands. It drives the ALU for a fixed number of settle cycles, then returns the result, tagged with the requester index, over a second valid/ready handshake. It sits between the issue stage and the shared ALU in the MCU datapath.

---
 rtl/alu_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 28 ++
 rtl/alu_share_arb.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and ALU opcode constants for the shared-ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'hd;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first set request
// at or above ptr_i, wrapping modulo REQ.
module rr_pick #(
  parameter int unsigned REQ = 4,
  parameter int unsigned IDW = $clog2(REQ)
) (
  input  logic [REQ-1:0] req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [REQ-1:0] gnt_o
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < REQ; i++) begin
      idx = IDW'((32'(ptr_i) + i) % REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one ALU among REQ requesters.
// Optional ALU_ARB_STATS_EN adds saturating handshake/stall counters.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned n       = 32,
  parameter int unsigned REQ     = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned IDW     = $clog2(REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REQ-1:0]   req_valid_i,
  output logic [REQ-1:0]   req_ready_o,
  input  logic [REQ*n-1:0] req_op0_i,
  input  logic [REQ*n-1:0] req_op1_i,
  input  logic [REQ*4-1:0] req_aluop_i,
  output logic [n-1:0]     alu_operand0_o,
  output logic [n-1:0]     alu_operand1_o,
  output logic [3:0]       alu_op_o,
  input  logic [n-1:0]     alu_data_i,
  input  logic             alu_bru_exp_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [IDW-1:0]   rsp_id_o,
  output logic [n-1:0]     rsp_data_o,
  output logic             rsp_bru_o
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]      stat_ops_o,
  output logic [31:0]      stat_stall_o
`endif
);

  localparam int unsigned LCW = 2;

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [LCW-1:0] lat_cnt_q, lat_cnt_d;
  logic [n-1:0]   op0_q, op0_d, op1_q, op1_d, data_q, data_d;
  logic [3:0]     aluop_q, aluop_d;
  logic [IDW-1:0] id_q, id_d;
  logic           bru_q, bru_d, rsp_valid_q, rsp_valid_d;

  logic [REQ-1:0] gnt;
  logic [IDW-1:0] sel_id;
  logic [n-1:0]   sel_op0, sel_op1;
  logic [3:0]     sel_aluop;

  rr_pick #(.REQ(REQ), .IDW(IDW)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  // Steer the granted lane's payload
  always_comb begin
    sel_id    = '0;
    sel_op0   = '0;
    sel_op1   = '0;
    sel_aluop = '0;
    for (int unsigned i = 0; i < REQ; i++) begin
      if (gnt[i]) begin
        sel_id    = IDW'(i);
        sel_op0   = req_op0_i[i*n +: n];
        sel_op1   = req_op1_i[i*n +: n];
        sel_aluop = req_aluop_i[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lat_cnt_q   <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
      aluop_q     <= '0;
      id_q        <= '0;
      data_q      <= '0;
      bru_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_cnt_q   <= lat_cnt_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      aluop_q     <= aluop_d;
      id_q        <= id_d;
      data_q      <= data_d;
      bru_q       <= bru_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lat_cnt_d = lat_cnt_q;
    op0_d     = op0_q;
    op1_d     = op1_q;
    aluop_d   = aluop_q;
    id_d      = id_q;
    data_d    = data_q;
    bru_d     = bru_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          op0_d     = sel_op0;
          op1_d     = sel_op1;
          aluop_d   = sel_aluop;
          id_d      = sel_id;
          rr_ptr_d  = (sel_id == IDW'(REQ - 1)) ? '0 : sel_id + 1'b1;
          lat_cnt_d = LCW'(ALU_LAT - 1);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end else begin
          data_d  = alu_data_i;
          bru_d   = alu_bru_exp_i;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  assign req_ready_o    = (state_q == IDLE) ? gnt : '0;
  assign alu_operand0_o = op0_q;
  assign alu_operand1_o = op1_q;
  assign alu_op_o       = aluop_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_id_o       = id_q;
  assign rsp_data_o     = data_q;
  assign rsp_bru_o      = bru_q;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] ops_q, stall_q;

  // Saturating counters of response handshakes and back-pressure cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else if (rsp_valid_q) begin
      if (rsp_ready_i) begin
        if (ops_q != '1) ops_q <= ops_q + 32'd1;
      end else begin
        if (stall_q != '1) stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_ops_o   = ops_q;
  assign stat_stall_o = stall_q;
`endif

endmodule
